clken_sched: RTL and testbench

//   Programmable clock-enable scheduler for the 60 MHz system clock domain.

---
 rtl/clken_sched_if.sv | 15 +
 rtl/clken_sched.sv | 113 +++++++++++
 tb/tb_clken_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/clken_sched_if.sv
// Config request channel for clken_sched: one valid/ready transfer reprograms one tick channel.
interface clken_sched_if #(
  parameter int N_CH  = 3,
  parameter int DIV_W = 10,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/clken_sched.sv
// Clock-enable scheduler: N_CH divided tick strobes on clk, each reprogrammable at a period boundary.
module clken_ch #(
  parameter int DIV_W   = 10,
  parameter int DEF_DIV = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_req,
  input  logic             acc,
  input  logic [DIV_W-1:0] acc_div,
  input  logic             acc_en,
  output logic             tick,
  output logic             pend
);
  localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, div_nxt_q, div_nxt_d;
  logic             en_cur_q, en_cur_d, en_nxt_q, en_nxt_d;
  logic             pend_q, pend_d, tick_q, tick_d;
  logic             wrap, apply;

  always_comb begin
    wrap      = en_cur_q && (cnt_q == div_cur_q - ONE);
    // a disabled channel has no boundary to wait for, so it takes the update at once
    apply     = pend_q && (!en_cur_q || wrap || sync_req);
    tick_d    = wrap && !sync_req;
    cnt_d     = (sync_req || wrap || !en_cur_q) ? '0 : cnt_q + ONE;
    div_cur_d = div_cur_q;
    en_cur_d  = en_cur_q;
    div_nxt_d = div_nxt_q;
    en_nxt_d  = en_nxt_q;
    pend_d    = pend_q;
    if (apply) begin
      div_cur_d = div_nxt_q;
      en_cur_d  = en_nxt_q;
      pend_d    = 1'b0;
      cnt_d     = '0;
    end
    // acc only fires while pend_q=0, so it never collides with apply
    if (acc) begin
      div_nxt_d = acc_div;
      en_nxt_d  = acc_en;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_cur_q <= DEF_V;
      en_cur_q  <= 1'b1;
      div_nxt_q <= DEF_V;
      en_nxt_q  <= 1'b1;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      en_cur_q  <= en_cur_d;
      div_nxt_q <= div_nxt_d;
      en_nxt_q  <= en_nxt_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;
  assign pend = pend_q;
endmodule

module clken_sched #(
  parameter int N_CH    = 3,
  parameter int DIV_W   = 10,
  parameter int DEF_DIV = 32
) (
  input  logic            clk,
  input  logic            rst,
  clken_sched_if.slave    cfg,
  input  logic            sync_req,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] pend
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CH_N = 1 << CH_W;

  logic [CH_N-1:0]  pend_pad;
  logic             ch_ok;
  logic [DIV_W-1:0] div_sat;
  logic [N_CH-1:0]  acc;

  // requests to channels that do not exist are accepted and dropped
  always_comb begin
    pend_pad              = '0;
    pend_pad[N_CH-1:0]    = pend;
    ch_ok                 = {1'b0, cfg.cfg_ch} < (CH_W+1)'(N_CH);
    cfg.cfg_ready         = !(ch_ok && pend_pad[cfg.cfg_ch]);
    div_sat               = (cfg.cfg_div == '0) ? DIV_W'(1) : cfg.cfg_div;
    for (int i = 0; i < N_CH; i++)
      acc[i] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(i));
  end

  clken_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch [N_CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .sync_req (sync_req),
    .acc      (acc),
    .acc_div  (div_sat),
    .acc_en   (cfg.cfg_en),
    .tick     (tick),
    .pend     (pend)
  );
endmodule

// File: tb/tb_clken_sched.sv
// Directed bench for clken_sched: vector table for config/sync timelines plus hand sequences for disable and reset.
module tb_clken_sched;
  localparam int N_CH = 3;
  localparam int DIV_W = 10;

  logic clk = 1'b0;
  logic rst;
  logic sync_req;
  logic [N_CH-1:0] tick, pend;
  int total = 0, bad = 0, cyc = 0;

  clken_sched_if #(.N_CH(N_CH), .DIV_W(DIV_W)) cif ();

  clken_sched #(.N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cif.slave),
    .sync_req (sync_req),
    .tick     (tick),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    int         cyc;
    bit         v;
    logic [1:0] ch;
    logic [9:0] div;
    bit         en;
    bit         sync;
    logic [2:0] e_tick;
    logic [2:0] e_pend;
    bit         e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic drive(input bit v, input logic [1:0] ch, input logic [9:0] div, input bit en, input bit sy);
    cif.cfg_valid = v;
    cif.cfg_ch    = ch;
    cif.cfg_div   = div;
    cif.cfg_en    = en;
    sync_req      = sy;
  endtask

  // cycle 0 is the first cycle with rst low
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic add(input bit r, input int c, input bit v, input logic [1:0] ch, input logic [9:0] d,
                     input bit en, input bit sy, input logic [2:0] et, input logic [2:0] ep, input bit er);
    vec_t x;
    x.do_rst = r; x.cyc = c; x.v = v; x.ch = ch; x.div = d; x.en = en; x.sync = sy;
    x.e_tick = et; x.e_pend = ep; x.e_rdy = er;
    tbl.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    // defaults, staged divisor 4 on ch1, stalled second request (div 6), out-of-range channel
    add(1,  0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
    add(0, 10, 1, 1, 4, 1, 0, 3'b000, 3'b000, 1);
    add(0, 11, 0, 1, 0, 0, 0, 3'b000, 3'b010, 0);
    add(0, 12, 1, 1, 6, 1, 0, 3'b000, 3'b010, 0);
    add(0, 31, 1, 1, 6, 1, 0, 3'b000, 3'b010, 0);
    add(0, 32, 1, 1, 6, 1, 0, 3'b111, 3'b000, 1);
    add(0, 33, 0, 1, 0, 0, 0, 3'b000, 3'b010, 0);
    add(0, 35, 0, 1, 0, 0, 0, 3'b000, 3'b010, 0);
    add(0, 36, 0, 1, 0, 0, 0, 3'b010, 3'b000, 1);
    add(0, 40, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1);
    add(0, 42, 0, 1, 0, 0, 0, 3'b010, 3'b000, 1);
    add(0, 48, 0, 1, 0, 0, 0, 3'b010, 3'b000, 1);
    add(0, 64, 0, 1, 0, 0, 0, 3'b101, 3'b000, 1);
    add(0, 66, 0, 1, 0, 0, 0, 3'b010, 3'b000, 1);
    add(0, 70, 1, 3, 5, 1, 0, 3'b000, 3'b000, 1);
    add(0, 71, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1);
    add(0, 72, 0, 0, 0, 0, 0, 3'b010, 3'b000, 1);
    // sync at 50 with a same-edge accept on ch2, then sync applying a pending ch1 update
    add(1,  32, 0, 0, 0, 0, 0, 3'b111, 3'b000, 1);
    add(0,  50, 1, 2, 8, 1, 1, 3'b000, 3'b000, 1);
    add(0,  51, 0, 2, 0, 0, 0, 3'b000, 3'b100, 0);
    add(0,  64, 0, 2, 0, 0, 0, 3'b000, 3'b100, 0);
    add(0,  82, 0, 2, 0, 0, 0, 3'b000, 3'b100, 0);
    add(0,  83, 0, 2, 0, 0, 0, 3'b111, 3'b000, 1);
    add(0,  90, 1, 1, 3, 1, 0, 3'b000, 3'b000, 1);
    add(0,  91, 0, 1, 0, 0, 0, 3'b100, 3'b010, 0);
    add(0,  95, 0, 1, 0, 0, 1, 3'b000, 3'b010, 0);
    add(0,  96, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1);
    add(0,  99, 0, 1, 0, 0, 0, 3'b010, 3'b000, 1);
    add(0, 102, 0, 1, 0, 0, 0, 3'b010, 3'b000, 1);
    add(0, 104, 0, 1, 0, 0, 0, 3'b100, 3'b000, 1);
    add(0, 128, 0, 1, 0, 0, 0, 3'b101, 3'b000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      if (cyc > tbl[i].cyc) chk($sformatf("row%0d_order", i), cyc, tbl[i].cyc);
      run_to(tbl[i].cyc);
      drive(tbl[i].v, tbl[i].ch, tbl[i].div, tbl[i].en, tbl[i].sync);
      #1;
      chk($sformatf("row%0d_tick", i), tick, tbl[i].e_tick);
      chk($sformatf("row%0d_pend", i), pend, tbl[i].e_pend);
      chk($sformatf("row%0d_rdy", i), cif.cfg_ready, tbl[i].e_rdy);
    end

    // disable ch0 at 5 (applied at its wrap), re-enable with div 0 -> every cycle from 43
    do_reset();
    run_to(5);  drive(1, 0, 32, 0, 0); #1; chk("dis_rdy", cif.cfg_ready, 1);
    step();     drive(0, 0, 0, 0, 0);  #1; chk("dis_pend", pend, 3'b001);
    run_to(31); chk("dis_t31", tick, 3'b000); chk("dis_p31", pend, 3'b001);
    run_to(32); chk("dis_t32", tick, 3'b111); chk("dis_p32", pend, 3'b000);
    run_to(40); drive(1, 0, 0, 1, 0); #1; chk("en_rdy", cif.cfg_ready, 1);
    step();     drive(0, 0, 0, 0, 0); #1; chk("en_p41", pend, 3'b001); chk("en_t41", tick, 3'b000);
    run_to(42); chk("en_t42", tick, 3'b000); chk("en_p42", pend, 3'b000);
    run_to(43); chk("en_t43", tick, 3'b001);
    run_to(44); chk("en_t44", tick, 3'b001);
    run_to(63); chk("en_t63", tick, 3'b001);
    run_to(64); chk("en_t64", tick, 3'b111);

    // reset while ch2 holds a staged div 7: it must be discarded
    run_to(70); drive(1, 2, 7, 1, 0);
    step();     drive(0, 2, 0, 0, 0); #1; chk("rs_pend", pend, 3'b100);
    do_reset();
    cif.cfg_ch = 2; #1;
    chk("rs_p0", pend, 3'b000); chk("rs_t0", tick, 3'b000); chk("rs_rdy", cif.cfg_ready, 1);
    run_to(31); chk("rs_t31", tick, 3'b000);
    run_to(32); chk("rs_t32", tick, 3'b111);
    run_to(33); chk("rs_t33", tick, 3'b000);
    run_to(39); chk("rs_t39", tick, 3'b000);
    run_to(64); chk("rs_t64", tick, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
